// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction memory controller.
package imem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } imem_state_t;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1024;
    localparam int RD_LAT_DEF = 1;

endpackage

// File: rtl/imem_rd_pipe.sv
// Read-response delay line: valid, data and side bits, RD_LAT registered stages.
module imem_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int SIDE_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [SIDE_W-1:0] side_q [RD_LAT];

    // Data/side stages only load with a valid beat so the output holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
                side_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
                side_q[0] <= in_side;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                    side_q[i] <= side_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];
    assign out_side  = side_q[RD_LAT-1];

endmodule

// File: rtl/imem_ctrl.sv
// Word memory with byte-enable writes, power-up clear sequence and fixed-latency reads.
// Optional per-byte even parity with error injection when IMEM_PARITY_EN is defined.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
`ifdef IMEM_PARITY_EN
    input  logic                inj_perr,
    output logic                rsp_perr,
`endif
    output logic                busy
);

    localparam int NB = DATA_W / 8;
`ifdef IMEM_PARITY_EN
    localparam int SIDE_W = 2;
`else
    localparam int SIDE_W = 1;
`endif

    imem_state_t        state;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               acc;
    logic               in_range;
    logic               wr_en;
    logic               rd_en;
    logic [DATA_W-1:0]  rd_data;
    logic [SIDE_W-1:0]  rd_side;
    logic [SIDE_W-1:0]  out_side;

    assign acc      = req_valid && req_ready;
    assign in_range = 32'(req_addr) < DEPTH;
    assign wr_en    = acc && req_write && in_range;
    assign rd_en    = acc && !req_write;
    assign rd_data  = in_range ? mem[req_addr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Memory is not reset; the CLEAR sweep provides the known-zero contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i]) begin
                        mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic          rd_perr;

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] d);
        byte_par = '0;
        for (int i = 0; i < NB; i++) begin
            byte_par[i] = ^d[8*i +: 8];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                par[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i]) begin
                        par[req_addr][i] <= (^req_wdata[8*i +: 8]) ^ inj_perr;
                    end
                end
            end
        end
    end

    assign rd_perr  = in_range && (|(par[req_addr] ^ byte_par(mem[req_addr])));
    assign rd_side  = {rd_perr, !in_range};
    assign rsp_perr = out_side[1] && rsp_valid;
`else
    assign rd_side  = !in_range;
`endif

    imem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .SIDE_W (SIDE_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_data   (rd_data),
        .in_side   (rd_side),
        .out_valid (rsp_valid),
        .out_data  (rsp_data),
        .out_side  (out_side)
    );

    assign rsp_err = out_side[0] && rsp_valid;

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: DEPTH=1000 (non power of two) and RD_LAT=2.
module tb_imem_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1000;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [NB-1:0]     req_be = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
`ifdef IMEM_PARITY_EN
    logic              inj_perr = 1'b0;
    logic              rsp_perr;
`endif

    imem_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
`ifdef IMEM_PARITY_EN
        .inj_perr  (inj_perr),
        .rsp_perr  (rsp_perr),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        logic              perr;
        int                due;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mdl [DEPTH];
    logic [NB-1:0]     mdl_bad [DEPTH];
    int                n_checks = 0;
    int                n_fail = 0;
    int                rsp_seen = 0;
    logic [DATA_W-1:0] last_exp = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_exp = '0;
        end else if (rsp_valid) begin
            rsp_seen++;
            if (sb.size() == 0) begin
                check_val("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("rsp_data", rsp_data, e.data);
                check_val("rsp_err", 32'(rsp_err), 32'(e.err));
                check_val("rsp_cycle", cyc, e.due);
`ifdef IMEM_PARITY_EN
                check_val("rsp_perr", 32'(rsp_perr), 32'(e.perr));
`endif
                last_exp = e.data;
            end
        end else begin
            check_val("hold_data", rsp_data, last_exp);
            check_val("idle_err", 32'(rsp_err), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input int addr, input logic [DATA_W-1:0] wd,
                         input logic [NB-1:0] be, input logic inj, input bit exp_acc);
        exp_t e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = ADDR_W'(addr);
        req_wdata = wd;
        req_be    = be;
`ifdef IMEM_PARITY_EN
        inj_perr  = inj;
`endif
        if (exp_acc) begin
            if (wr) begin
                if (addr < DEPTH) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[b]) begin
                            mdl[addr][8*b +: 8] = wd[8*b +: 8];
                            mdl_bad[addr][b]    = inj;
                        end
                    end
                end
            end else begin
                e.data = (addr < DEPTH) ? mdl[addr] : '0;
                e.err  = (addr >= DEPTH);
                e.perr = (addr < DEPTH) ? (|mdl_bad[addr]) : 1'b0;
                e.due  = cyc + RD_LAT;
                sb.push_back(e);
            end
        end
        tick();
        req_valid = 1'b0;
`ifdef IMEM_PARITY_EN
        inj_perr  = 1'b0;
`endif
    endtask

    task automatic zero_model();
        for (int a = 0; a < DEPTH; a++) begin
            mdl[a]     = '0;
            mdl_bad[a] = '0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        req_valid = 1'b0;
        sb.delete();
        repeat (cycles) tick();
        rst = 1'b0;
        zero_model();
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        check_val(tag, n, DEPTH);
        check_val("ready_after_clear", 32'(req_ready), 32'd1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        zero_model();
        repeat (2) tick();
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd1);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_data", rsp_data, 32'd0);
        check_val("rst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        rst = 1'b0;
        wait_clear("clear_cycles");

        issue(0, 0, '0, '1, 0, 1);
        issue(0, 7, '0, '1, 0, 1);
        issue(0, DEPTH - 1, '0, '1, 0, 1);

        issue(1, 5, 32'hDEADBEEF, 4'b1111, 0, 1);
        issue(1, 5, 32'h11223344, 4'b0101, 0, 1);
        issue(0, 5, '0, '1, 0, 1);
        check_val("merge_model", mdl[5], 32'hDE22BE44);

        issue(1, 0, 32'hA, 4'b1111, 0, 1);
        issue(1, 1, 32'hB, 4'b1111, 0, 1);
        issue(1, 2, 32'hC, 4'b1111, 0, 1);
        tick();
        issue(0, 0, '0, '1, 0, 1);
        issue(0, 1, '0, '1, 0, 1);
        issue(0, 2, '0, '1, 0, 1);

        issue(1, 9, 32'h12345678, 4'b1111, 0, 1);
        issue(0, 9, '0, '1, 0, 1);

        issue(1, 5, 32'hFFFFFFFF, 4'b0000, 0, 1);
        issue(0, 5, '0, '1, 0, 1);

        issue(0, DEPTH, '0, '1, 0, 1);
        issue(0, (1 << ADDR_W) - 1, '0, '1, 0, 1);
        issue(1, DEPTH, 32'h55555555, 4'b1111, 0, 1);
        issue(0, 0, '0, '1, 0, 1);
        issue(0, DEPTH, '0, '1, 0, 1);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) tick();
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << ADDR_W) - 1)),
                  $urandom, NB'($urandom_range(0, (1 << NB) - 1)), 0, 1);
        end

`ifdef IMEM_PARITY_EN
        issue(1, 20, 32'h000000FF, 4'b0001, 1, 1);
        issue(0, 20, '0, '1, 0, 1);
        issue(1, 20, 32'h000000FF, 4'b0001, 0, 1);
        issue(0, 20, '0, '1, 0, 1);
`endif
        repeat (RD_LAT + 2) tick();
        check_val("sb_drained", sb.size(), 0);

        seen0 = rsp_seen;
        issue(0, 5, '0, '1, 0, 1);
        do_reset(2);
        wait_clear("clear_after_flush");
        check_val("flushed_rsp", rsp_seen - seen0, 0);

        do_reset(2);
        issue(1, 3, 32'hFFFFFFFF, 4'b1111, 0, 0);
        issue(0, 3, '0, '1, 0, 0);
        repeat (498) tick();
        @(negedge clk);
        check_val("busy_mid_clear", 32'(busy), 32'd1);
        tick();
        do_reset(1);
        wait_clear("clear_after_midreset");
        issue(0, 3, '0, '1, 0, 1);
        issue(0, DEPTH - 1, '0, '1, 0, 1);

        repeat (RD_LAT + 2) tick();
        check_val("sb_final", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words (any value 2..65536).
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), request address width.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles (legal 1 or 2).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  ADDR_W  word address.
REQ-011 SHALL have port req_wdata  input  DATA_W  write data.
REQ-012 SHALL have port req_be  input  DATA_W/8  byte enables for writes.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle pulse per accepted read.
REQ-014 SHALL have port rsp_data  output  DATA_W  read data, holds last value when rsp_valid=0.
REQ-015 SHALL have port rsp_err  output  1  accompanies rsp_valid; out-of-range read.
REQ-016 SHALL have port busy  output  1  high while clearing memory.

Function
REQ-017 SHALL implement FSM states CLEAR and IDLE; reset enters CLEAR with clear counter=0.
REQ-018 In CLEAR SHALL write zero to word[counter] each cycle, increment counter, go to IDLE after word DEPTH-1 (DEPTH cycles total); busy=1, req_ready=0.
REQ-019 In IDLE SHALL hold req_ready=1 and busy=0; no other state exits IDLE.
REQ-020 Accepted read SHALL return word[req_addr] on rsp_data with rsp_valid=1 exactly RD_LAT cycles after acceptance edge; back-to-back reads SHALL sustain one response per cycle.
REQ-021 Accepted write SHALL update only bytes with req_be[i]=1 at the acceptance edge; no response generated.
REQ-022 Read accepted the cycle after a write to same address SHALL return the newly written bytes.
REQ-023 req_addr >= DEPTH: write SHALL be discarded; read SHALL return rsp_data=0 with rsp_err=1.
REQ-024 req_be=0 write SHALL leave memory unchanged.
REQ-025 Requests presented while req_ready=0 SHALL be ignored with no side effect.

Reset
REQ-026 Reset values: rsp_valid=0, rsp_data=0, rsp_err=0, busy=1 (first cycle after reset), req_ready=0, read pipeline valid bits=0.
REQ-027 Reset asserted mid-CLEAR SHALL restart clearing from word 0; reset in IDLE SHALL drop all in-flight reads (no rsp_valid produced).

Configuration
REQ-028 Macro IMEM_PARITY_EN, when defined, SHALL store one even-parity bit per byte, add output rsp_perr (1 bit, reset 0) asserted with rsp_valid when any enabled byte's stored parity mismatches, and add input inj_perr (1 bit) that inverts stored parity of written bytes.
REQ-029 Without IMEM_PARITY_EN, no parity storage, rsp_perr and inj_perr ports SHALL be absent.

Structure
REQ-030 Package imem_pkg SHALL hold FSM state enum (CLEAR, IDLE) and default parameter constants.
REQ-031 Read-latency valid/data/err pipeline SHALL be sub-module imem_rd_pipe parametrised by RD_LAT and DATA_W.

Verification
REQ-032 Reset, DEPTH=1024: busy=1 for 1024 cycles, then req_ready=1; read any address -> 0x00000000.
REQ-033 Write 0xDEADBEEF be=4'b1111 addr 5, then write 0x11223344 be=4'b0101 addr 5, read addr 5 -> 0xDE22BE44 after RD_LAT cycles.
REQ-034 RD_LAT=2, reads addr 0,1,2 back-to-back (prior data 0xA,0xB,0xC) -> rsp_valid 3 consecutive cycles, data 0xA,0xB,0xC in order.
REQ-035 DEPTH=1000, read addr 1000 -> rsp_data=0, rsp_err=1; write addr 1000 then read addr 1000-1000 wraps nowhere: addr 0 unchanged.
REQ-036 Reset asserted at clear cycle 500 -> busy stays 1 for 1024 further cycles; reset during in-flight read -> no rsp_valid.
REQ-037 IMEM_PARITY_EN: write 0xFF be=4'b0001 with inj_perr=1, read back -> rsp_perr=1; rewrite without inj_perr -> rsp_perr=0.
